// File: rtl/net_switch_pkg.sv
// Shared constants and routing helpers for the flattened-network crossbar.
// Port k answers to destination ID (1<<k); anything else is unroutable.
package net_switch_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int STATS_W    = 32;
  localparam int MAX_PORTS  = 16;
  localparam int MAX_ID_W   = 64;

  function automatic logic [MAX_ID_W-1:0] id_of(input int k);
    return MAX_ID_W'(1) << k;
  endfunction

  // One-hot output select; all-zero means the ID matches no port.
  function automatic logic [MAX_PORTS-1:0] route_decode(input logic [MAX_ID_W-1:0] id,
                                                        input int num_ports);
    logic [MAX_PORTS-1:0] oh;
    oh = '0;
    for (int j = 0; j < MAX_PORTS; j++) begin
      if (j < num_ports && id == id_of(j)) oh[j] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/net_switch_fifo.sv
// Per-input packet FIFO: extra-MSB pointers, combinational head, async active-low reset.
// Push while full and pop while empty are ignored.
module net_switch_fifo
  import net_switch_pkg::*;
#(
  parameter int PACKET_W_P   = 64,
  parameter int FIFO_DEPTH_P = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [PACKET_W_P-1:0] i_data,
  input  logic                  i_pop,
  output logic [PACKET_W_P-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH_P);

  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [PACKET_W_P-1:0] r_mem [FIFO_DEPTH_P];
  logic                  w_wr;
  logic                  w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/net_switch_flattened.sv
// N-port crossbar: per-input FIFOs, destination-ID routing, per-output round-robin, registered outputs.
// Define NET_SWITCH_STATS_EN to build per-output forwarded-packet counters on stats_flat_o.
module net_switch_flattened
  import net_switch_pkg::*;
#(
  parameter int NUM_PORTS_P  = 4,
  parameter int PACKET_W_P   = 64,
  parameter int ID_W_P       = 10,
  parameter int ID_LSB_P     = 0,
  parameter int FIFO_DEPTH_P = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS_P*PACKET_W_P-1:0] packet_flat_i,
  input  logic [NUM_PORTS_P-1:0]            valid_i,
  output logic [NUM_PORTS_P-1:0]            ready_o,
  output logic [NUM_PORTS_P*PACKET_W_P-1:0] packet_flat_o,
  output logic [NUM_PORTS_P-1:0]            valid_o,
  input  logic [NUM_PORTS_P-1:0]            ready_i,
  output logic                              drop_o,
  output logic [DROP_CNT_W-1:0]             drop_count_o,
  output logic [NUM_PORTS_P*STATS_W-1:0]    stats_flat_o
);

  localparam int PTR_W = $clog2(NUM_PORTS_P);

  logic                   r_ready_en;
  logic [NUM_PORTS_P-1:0] w_full;
  logic [NUM_PORTS_P-1:0] w_empty;
  logic [NUM_PORTS_P-1:0] w_push;
  logic [NUM_PORTS_P-1:0] w_pop;
  logic [NUM_PORTS_P-1:0] w_unroute;
  logic [NUM_PORTS_P-1:0] w_loadable;
  logic [NUM_PORTS_P-1:0] w_gvalid;
  logic [PACKET_W_P-1:0]  w_head  [NUM_PORTS_P];
  logic [NUM_PORTS_P-1:0] w_route [NUM_PORTS_P];  // [input][output]
  logic [NUM_PORTS_P-1:0] w_grant [NUM_PORTS_P];  // [output][input]
  logic [PTR_W-1:0]       w_gidx  [NUM_PORTS_P];
  logic [PTR_W-1:0]       r_ptr   [NUM_PORTS_P];
  logic [NUM_PORTS_P-1:0] r_valid;
  logic [PACKET_W_P-1:0]  r_data  [NUM_PORTS_P];
  logic [DROP_CNT_W-1:0]  r_drop_cnt;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS_P) s = s - NUM_PORTS_P;
    return PTR_W'(s);
  endfunction

  // Holds ready_o low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  assign ready_o = {NUM_PORTS_P{r_ready_en}} & ~w_full;
  assign w_push  = valid_i & ready_o;

  for (genvar k = 0; k < NUM_PORTS_P; k++) begin : g_in
    logic [MAX_PORTS-1:0] w_dec;

    net_switch_fifo #(
      .PACKET_W_P   (PACKET_W_P),
      .FIFO_DEPTH_P (FIFO_DEPTH_P)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[k]),
      .i_data  (packet_flat_i[k*PACKET_W_P +: PACKET_W_P]),
      .i_pop   (w_pop[k]),
      .o_data  (w_head[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k])
    );

    assign w_dec        = route_decode(MAX_ID_W'(w_head[k][ID_LSB_P +: ID_W_P]), NUM_PORTS_P);
    assign w_route[k]   = w_empty[k] ? '0 : w_dec[NUM_PORTS_P-1:0];
    assign w_unroute[k] = !w_empty[k] && (w_dec == '0);
  end

  assign w_loadable = ~r_valid | ready_i;

  // Round-robin: first requester at or above r_ptr[j], wrapping.
  always_comb begin
    for (int j = 0; j < NUM_PORTS_P; j++) begin
      w_grant[j]  = '0;
      w_gidx[j]   = '0;
      w_gvalid[j] = 1'b0;
      for (int off = 0; off < NUM_PORTS_P; off++) begin
        if (w_loadable[j] && !w_gvalid[j] && w_route[wrap_add(r_ptr[j], off)][j]) begin
          w_gidx[j]   = wrap_add(r_ptr[j], off);
          w_gvalid[j] = 1'b1;
        end
      end
      if (w_gvalid[j]) w_grant[j][w_gidx[j]] = 1'b1;
    end
  end

  always_comb begin
    w_pop = w_unroute;
    for (int j = 0; j < NUM_PORTS_P; j++) begin
      w_pop = w_pop | w_grant[j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int j = 0; j < NUM_PORTS_P; j++) begin
        r_data[j] <= '0;
        r_ptr[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS_P; j++) begin
        if (w_gvalid[j]) begin
          r_valid[j] <= 1'b1;
          r_data[j]  <= w_head[w_gidx[j]];
          r_ptr[j]   <= (w_gidx[j] == PTR_W'(NUM_PORTS_P-1)) ? '0 : w_gidx[j] + 1'b1;
        end else if (ready_i[j]) begin
          r_valid[j] <= 1'b0;
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS_P; j++) begin : g_out
    assign packet_flat_o[j*PACKET_W_P +: PACKET_W_P] = r_data[j];
  end
  assign valid_o = r_valid;

  // Simultaneous drops on several inputs count as a single event.
  assign drop_o = |w_unroute;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           r_drop_cnt <= '0;
    else if (drop_o && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + 1'b1;
  end
  assign drop_count_o = r_drop_cnt;

`ifdef NET_SWITCH_STATS_EN
  logic [STATS_W-1:0] r_stats [NUM_PORTS_P];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NUM_PORTS_P; j++) r_stats[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS_P; j++) begin
        if (r_valid[j] && ready_i[j]) r_stats[j] <= r_stats[j] + 1'b1;
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS_P; j++) begin : g_stats
    assign stats_flat_o[j*STATS_W +: STATS_W] = r_stats[j];
  end
`else
  assign stats_flat_o = '0;
`endif

endmodule

// File: tb/tb_net_switch_flattened.sv
// Scoreboard bench for net_switch_flattened: directed vectors push expected packets per output,
// a negedge monitor pops and compares on every output handshake.
module tb_net_switch_flattened;

  localparam int NP = 4;
  localparam int PW = 64;

  logic               clk;
  logic               reset;
  logic [NP*PW-1:0]   packet_flat_i;
  logic [NP-1:0]      valid_i;
  logic [NP-1:0]      ready_o;
  logic [NP*PW-1:0]   packet_flat_o;
  logic [NP-1:0]      valid_o;
  logic [NP-1:0]      ready_i;
  logic               drop_o;
  logic [15:0]        drop_count_o;
  logic [NP*32-1:0]   stats_flat_o;

  int checks   = 0;
  int failures = 0;
  int drop_pulses = 0;

  logic [PW-1:0] tx_q  [NP][$];
  logic [PW-1:0] exp_q [NP][$];
  logic [PW-1:0] mon_exp;
  logic [PW-1:0] pkt0;

  net_switch_flattened dut (
    .clk           (clk),
    .reset         (reset),
    .packet_flat_i (packet_flat_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .packet_flat_o (packet_flat_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .drop_o        (drop_o),
    .drop_count_o  (drop_count_o),
    .stats_flat_o  (stats_flat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic [9:0] id, input logic [31:0] pl);
    return {16'h0, pl, 6'h0, id};
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of that output's queue.
  always @(negedge clk) begin
    if (reset) begin
      for (int j = 0; j < NP; j++) begin
        if (valid_o[j] && ready_i[j]) begin
          checks++;
          if (exp_q[j].size() == 0) begin
            failures++;
            $display("FAIL out%0d_unexpected got=%0h expected=none", j, packet_flat_o[j*PW +: PW]);
          end else begin
            mon_exp = exp_q[j].pop_front();
            if (packet_flat_o[j*PW +: PW] !== mon_exp) begin
              failures++;
              $display("FAIL out%0d_data got=%0h expected=%0h", j, packet_flat_o[j*PW +: PW], mon_exp);
            end
          end
        end
      end
      if (drop_o) drop_pulses++;
    end
  end

  function automatic bit pending();
    for (int k = 0; k < NP; k++) if (tx_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Call right after a posedge; returns right after a posedge.
  task automatic drive_all(input int budget);
    int cyc;
    logic [NP-1:0] acc;
    cyc = 0;
    while (pending() && cyc < budget) begin
      for (int k = 0; k < NP; k++) begin
        if (tx_q[k].size() > 0) begin
          valid_i[k] = 1'b1;
          packet_flat_i[k*PW +: PW] = tx_q[k][0];
        end else begin
          valid_i[k] = 1'b0;
        end
      end
      @(negedge clk);
      acc = valid_i & ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < NP; k++) if (acc[k]) void'(tx_q[k].pop_front());
      cyc++;
    end
    valid_i = '0;
    checks++;
    if (pending()) begin
      failures++;
      $display("FAIL drive_timeout got=pending expected=all_sent");
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    valid_i = '0;
    ready_i = '1;
    for (int k = 0; k < NP; k++) begin
      tx_q[k].delete();
      exp_q[k].delete();
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cyc;
    reset = 1'b0;
    valid_i = '0;
    ready_i = '1;
    packet_flat_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", 256'(valid_o), 256'(0));
    chk("rst_ready_o", 256'(ready_o), 256'(0));
    chk("rst_drop_o", 256'(drop_o), 256'(0));
    chk("rst_drop_count", 256'(drop_count_o), 256'(0));
    chk("rst_stats", 256'(stats_flat_o), 256'(0));
    reset = 1'b1;
    #1 chk("ready_before_edge", 256'(ready_o), 256'(0));
    @(negedge clk);
    chk("ready_after_edge", 256'(ready_o), 256'(4'hF));

    // Single packet latency: port0 -> ID 0x004 -> output 2
    pkt0 = mk(10'h004, 32'hA5);
    packet_flat_i[0 +: PW] = pkt0;
    valid_i = 4'b0001;
    exp_q[2].push_back(pkt0);
    @(posedge clk);
    #1 valid_i = '0;
    @(negedge clk);
    chk("lat_cycle1_valid", 256'(valid_o), 256'(0));
    @(negedge clk);
    chk("lat_cycle2_valid", 256'(valid_o), 256'(4'b0100));
    chk("lat_cycle2_data", 256'(packet_flat_o[2*PW +: PW]), 256'(pkt0));
    repeat (3) @(negedge clk);
    chk("lat_drained", 256'(exp_q[2].size()), 256'(0));

    // Round robin: ports 0,1,3 all target output 0
    do_reset();
    for (int s = 0; s < 6; s++) begin
      tx_q[0].push_back(mk(10'h001, 32'(16'h0000 + s)));
      tx_q[1].push_back(mk(10'h001, 32'(16'h0100 + s)));
      tx_q[3].push_back(mk(10'h001, 32'(16'h0300 + s)));
      exp_q[0].push_back(mk(10'h001, 32'(16'h0000 + s)));
      exp_q[0].push_back(mk(10'h001, 32'(16'h0100 + s)));
      exp_q[0].push_back(mk(10'h001, 32'(16'h0300 + s)));
    end
    drive_all(100);
    repeat (20) @(negedge clk);
    chk("rr_drained", 256'(exp_q[0].size()), 256'(0));

    // Backpressure: port1 -> output2 with ready_i[2]=0
    do_reset();
    ready_i[2] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tx_q[1].push_back(mk(10'h004, 32'h200 + 32'(s)));
      exp_q[2].push_back(mk(10'h004, 32'h200 + 32'(s)));
    end
    drive_all(50);
    @(negedge clk);
    chk("bp_ready1_low", 256'(ready_o), 256'(4'b1101));
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid_hold", 256'(valid_o), 256'(4'b0100));
      chk("bp_data_hold", 256'(packet_flat_o[2*PW +: PW]), 256'(mk(10'h004, 32'h200)));
      @(negedge clk);
    end
    @(posedge clk);
    #1 ready_i[2] = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_drained", 256'(exp_q[2].size()), 256'(0));
    chk("bp_ready_back", 256'(ready_o), 256'(4'hF));

    // Drops: unroutable IDs 0x000, 0x003, 0x010
    do_reset();
    drop_pulses = 0;
    tx_q[2].push_back(mk(10'h000, 32'h1));
    tx_q[2].push_back(mk(10'h003, 32'h2));
    tx_q[2].push_back(mk(10'h010, 32'h3));
    drive_all(20);
    repeat (5) @(negedge clk);
    chk("drop_pulses3", 256'(drop_pulses), 256'(3));
    chk("drop_count3", 256'(drop_count_o), 256'(3));
    chk("drop_no_valid", 256'(valid_o), 256'(0));

    // Saturation: push the counter to 0xFFFF, then one more drop
    @(posedge clk);
    #1;
    packet_flat_i[0 +: PW] = mk(10'h000, 32'h5);
    valid_i = 4'b0001;
    n = 0;
    cyc = 0;
    while (n < 65532 && cyc < 70000) begin
      @(negedge clk);
      if (ready_o[0]) n++;
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_i = '0;
    chk("sat_fill_count", 256'(n), 256'(65532));
    repeat (5) @(negedge clk);
    chk("sat_reach_ffff", 256'(drop_count_o), 256'(16'hFFFF));
    @(posedge clk);
    #1 tx_q[1].push_back(mk(10'h3FF, 32'h6));
    drive_all(20);
    repeat (4) @(negedge clk);
    chk("sat_hold_ffff", 256'(drop_count_o), 256'(16'hFFFF));
    chk("sat_pulses", 256'(drop_pulses), 256'(65536));

    // Reset mid-traffic with 3 packets queued toward output 1
    do_reset();
    ready_i[1] = 1'b0;
    for (int s = 0; s < 3; s++) tx_q[0].push_back(mk(10'h002, 32'h300 + 32'(s)));
    drive_all(20);
    @(negedge clk);
    chk("mid_queued_valid", 256'(valid_o), 256'(4'b0010));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(valid_o), 256'(0));
    chk("mid_rst_ready", 256'(ready_o), 256'(0));
    ready_i = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_after_valid", 256'(valid_o), 256'(0));
    chk("mid_after_drops", 256'(drop_count_o), 256'(0));
    chk("mid_after_stats", 256'(stats_flat_o), 256'(0));
    chk("mid_after_ready", 256'(ready_o), 256'(4'hF));

    // Ten handshakes on output 3
    @(posedge clk);
    #1;
    for (int s = 0; s < 10; s++) begin
      tx_q[0].push_back(mk(10'h008, 32'h400 + 32'(s)));
      exp_q[3].push_back(mk(10'h008, 32'h400 + 32'(s)));
    end
    drive_all(50);
    repeat (10) @(negedge clk);
    chk("st_drained", 256'(exp_q[3].size()), 256'(0));
`ifdef NET_SWITCH_STATS_EN
    chk("stats_out3_10", 256'(stats_flat_o), 256'({32'd10, 96'd0}));
`else
    chk("stats_tied_zero", 256'(stats_flat_o), 256'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/net_switch_flattened.md
Name: net_switch_flattened

Overview:
- Parametrised N-port crossbar for flattened network packets. Successor to the single-core flattened network boundary.
- Connects NUM_PORTS_P core net ports, routes each packet by its destination-ID field, and buffers per input.
- Per-output round-robin arbitration; registered outputs with valid/ready handshake on every port.

Parameters:
- NUM_PORTS_P, 4, number of core ports; 2..16.
- PACKET_W_P, 64, flattened packet width in bits.
- ID_W_P, 10, destination-ID field width; must be >= NUM_PORTS_P.
- ID_LSB_P, 0, bit position of the destination-ID field LSB within a packet.
- FIFO_DEPTH_P, 4, per-input FIFO depth; power of two, >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- packet_flat_i  input  NUM_PORTS_P*PACKET_W_P  input packets; port k occupies slice [k*PACKET_W_P +: PACKET_W_P].
- valid_i  input  NUM_PORTS_P  input packet valid, per port.
- ready_o  output  NUM_PORTS_P  input FIFO not full, per port.
- packet_flat_o  output  NUM_PORTS_P*PACKET_W_P  output packets; same slicing as packet_flat_i.
- valid_o  output  NUM_PORTS_P  output register holds a packet.
- ready_i  input  NUM_PORTS_P  downstream accepts the packet.
- drop_o  output  1  one-cycle pulse: at least one packet dropped this cycle.
- drop_count_o  output  16  saturating count of dropped packets.
- stats_flat_o  output  NUM_PORTS_P*32  per-output forwarded-packet counts (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): clears FIFOs and output registers; all arbiter pointers = 0; valid_o=0, ready_o=0, drop_o=0, drop_count_o=0, stats=0. In-flight packets are lost. ready_o rises on the first clk edge after reset deasserts.
- Port k has ID (1<<k). A packet whose ID field equals exactly (1<<j) routes to output j. Loopback (j=k) is legal. Any other value (0, multi-hot, bit >= NUM_PORTS_P) is unroutable.
- Enqueue on valid_i[k] & ready_o[k]. ready_o[k] = !full[k]. No enqueue when full, even if the FIFO dequeues in the same cycle.
- Output register j is loadable when !valid_o[j] | ready_i[j].
- Arbitration per output j: requesters are non-empty FIFO heads routed to j. Grant goes to the first requester scanning from ptr[j] upward, modulo N. After a grant to input i, ptr[j] = (i+1) mod N. No grant while output j is not loadable; ptr[j] holds.
- Granted head is dequeued and written to output register j on the same edge.
- Unroutable head is dequeued without output on the next edge: drop_o=1 that cycle and drop_count_o increments by 1, saturating at 0xFFFF. Several simultaneous drops count as one increment.
- Latency: packet presented in cycle 0 to an empty switch → valid_o in cycle 2. Sustained throughput is 1 packet/cycle/output.
- valid_o and packet_flat_o are stable while valid_o & !ready_i. Packets from one input to one output are delivered in order.
- FIFO pointers are log2(FIFO_DEPTH_P)+1 bits and wrap naturally. full = MSBs differ & LSBs equal; empty = pointers equal.

Optional Feature:
- NET_SWITCH_STATS_EN defined: stats_flat_o[j*32 +: 32] increments on each output-j handshake (valid_o[j] & ready_i[j]), wraps at 2^32, and clears on reset.
- Undefined: no counters are built and stats_flat_o is tied to 0. The port is always present.

Decomposition:
- Package net_switch_pkg holds the port-ID function id_of(k)=1<<k, the route-decode function (ID field → one-hot output or unroutable), and the DROP_CNT_W=16 and STATS_W=32 constants.
- Sub-module net_switch_fifo(PACKET_W_P, FIFO_DEPTH_P): synchronous FIFO with full/empty flags and the async active-low reset. Instantiated NUM_PORTS_P times. The arbiter stays inline.

Test Plan:
- Reset, then in 1 cycle inject port0 packet with ID=0x004, payload 0xA5; ready_i=all ones → valid_o[2]=1 in cycle 2 with payload 0xA5; other valid_o=0.
- Ports 0,1,3 each send continuously to ID=0x001 (port 0), ready_i[0]=1 → output 0 grants in order 0,1,3,0,1,3…; no input starves.
- Port1 sends 5 packets to port 2 while ready_i[2]=0 → ready_o[1] falls after the 5th accepted packet (4 in the FIFO + 1 in the output register). valid_o[2] and its data stay stable. Raising ready_i[2] drains all 5 in order.
- Port2 sends ID=0x000, then 0x003, then 0x010 → three drop_o pulses, drop_count_o=3, no valid_o. Preload drop_count_o to 0xFFFF, then one more drop → it stays 0xFFFF.
- Assert reset mid-traffic with 3 packets queued → valid_o=0 and ready_o=0 immediately. After release, nothing is emitted and the counters are 0.
- With NET_SWITCH_STATS_EN, 10 handshakes on output 3 → stats slice 3 = 10. Without the macro, stats_flat_o = 0.
